// File: rtl/rv32e_alu_arbiter.sv
// Two-port arbiter in front of one combinational rv32e_alu: port 0 has fixed priority, and a starvation guard lets port 1 through.
// Optional per-port grant and conflict statistics are built only when ALU_ARB_STATS_EN is defined.
module rv32e_alu_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid_0,
    output logic        req_ready_0,
    input  logic [3:0]  req_op_0,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_b_0,
    output logic        rsp_valid_0,
    input  logic        rsp_ready_0,
    output logic [31:0] rsp_result_0,
    output logic [2:0]  rsp_flags_0,

    input  logic        req_valid_1,
    output logic        req_ready_1,
    input  logic [3:0]  req_op_1,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_1,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_1,
    output logic [31:0] rsp_result_1,
    output logic [2:0]  rsp_flags_1,

    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        alu_ovf,

    output logic [31:0] stat_grant0,
    output logic [31:0] stat_grant1,
    output logic [31:0] stat_conflict
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic        elig0;
    logic        elig1;
    logic        grant0;
    logic        grant1;
    logic [2:0]  capFlags;

    logic [3:0]  starve_q, starve_d;
    logic        rsp_valid_0_q, rsp_valid_0_d;
    logic        rsp_valid_1_q, rsp_valid_1_d;
    logic [31:0] rsp_result_0_q, rsp_result_0_d;
    logic [31:0] rsp_result_1_q, rsp_result_1_d;
    logic [2:0]  rsp_flags_0_q, rsp_flags_0_d;
    logic [2:0]  rsp_flags_1_q, rsp_flags_1_d;

    // A port may be granted while its held response drains in the same cycle.
    assign elig0  = req_valid_0 && (!rsp_valid_0_q || rsp_ready_0);
    assign elig1  = req_valid_1 && (!rsp_valid_1_q || rsp_ready_1);
    assign grant1 = !rst && elig1 && (!elig0 || (starve_q == LIMIT));
    assign grant0 = !rst && elig0 && !grant1;

    assign req_ready_0 = grant0;
    assign req_ready_1 = grant1;
    assign capFlags    = {alu_ovf, alu_neg, alu_zero};

    always_comb begin
        alu_op = 4'b0000;
        alu_a  = 32'd0;
        alu_b  = 32'd0;
        if (grant0) begin
            alu_op = req_op_0;
            alu_a  = req_a_0;
            alu_b  = req_b_0;
        end else if (grant1) begin
            alu_op = req_op_1;
            alu_a  = req_a_1;
            alu_b  = req_b_1;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!elig1 || grant1) begin
            starve_d = 4'd0;
        end else if (grant0) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // A new grant wins over a drain, so the slot stays valid with fresh data.
    always_comb begin
        rsp_valid_0_d  = rsp_valid_0_q;
        rsp_result_0_d = rsp_result_0_q;
        rsp_flags_0_d  = rsp_flags_0_q;
        rsp_valid_1_d  = rsp_valid_1_q;
        rsp_result_1_d = rsp_result_1_q;
        rsp_flags_1_d  = rsp_flags_1_q;
        if (grant0) begin
            rsp_valid_0_d  = 1'b1;
            rsp_result_0_d = alu_result;
            rsp_flags_0_d  = capFlags;
        end else if (rsp_valid_0_q && rsp_ready_0) begin
            rsp_valid_0_d  = 1'b0;
        end
        if (grant1) begin
            rsp_valid_1_d  = 1'b1;
            rsp_result_1_d = alu_result;
            rsp_flags_1_d  = capFlags;
        end else if (rsp_valid_1_q && rsp_ready_1) begin
            rsp_valid_1_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q       <= 4'd0;
            rsp_valid_0_q  <= 1'b0;
            rsp_result_0_q <= 32'd0;
            rsp_flags_0_q  <= 3'd0;
            rsp_valid_1_q  <= 1'b0;
            rsp_result_1_q <= 32'd0;
            rsp_flags_1_q  <= 3'd0;
        end else begin
            starve_q       <= starve_d;
            rsp_valid_0_q  <= rsp_valid_0_d;
            rsp_result_0_q <= rsp_result_0_d;
            rsp_flags_0_q  <= rsp_flags_0_d;
            rsp_valid_1_q  <= rsp_valid_1_d;
            rsp_result_1_q <= rsp_result_1_d;
            rsp_flags_1_q  <= rsp_flags_1_d;
        end
    end

    assign rsp_valid_0  = rsp_valid_0_q;
    assign rsp_result_0 = rsp_result_0_q;
    assign rsp_flags_0  = rsp_flags_0_q;
    assign rsp_valid_1  = rsp_valid_1_q;
    assign rsp_result_1 = rsp_result_1_q;
    assign rsp_flags_1  = rsp_flags_1_q;

`ifdef ALU_ARB_STATS_EN
    logic [31:0] grant0Cnt_q;
    logic [31:0] grant1Cnt_q;
    logic [31:0] conflictCnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant0Cnt_q   <= 32'd0;
            grant1Cnt_q   <= 32'd0;
            conflictCnt_q <= 32'd0;
        end else begin
            if (grant0) grant0Cnt_q <= grant0Cnt_q + 32'd1;
            if (grant1) grant1Cnt_q <= grant1Cnt_q + 32'd1;
            if (elig0 && elig1) conflictCnt_q <= conflictCnt_q + 32'd1;
        end
    end

    assign stat_grant0   = grant0Cnt_q;
    assign stat_grant1   = grant1Cnt_q;
    assign stat_conflict = conflictCnt_q;
`else
    assign stat_grant0   = 32'd0;
    assign stat_grant1   = 32'd0;
    assign stat_conflict = 32'd0;
`endif

endmodule

// File: tb/tb_rv32e_alu_arbiter.sv
// Scoreboard bench for rv32e_alu_arbiter: the bench plays the ALU, predicts grants from the arbitration rules,
// queues expected responses per port, and a negedge monitor pops and compares them.
module tb_rv32e_alu_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        reqValid0 = 1'b0, reqValid1 = 1'b0;
    logic        reqReady0, reqReady1;
    logic [3:0]  reqOp0 = 4'd0, reqOp1 = 4'd0;
    logic [31:0] reqA0 = 32'd0, reqB0 = 32'd0, reqA1 = 32'd0, reqB1 = 32'd0;
    logic        rspValid0, rspValid1;
    logic        rspReady0 = 1'b0, rspReady1 = 1'b0;
    logic [31:0] rspResult0, rspResult1;
    logic [2:0]  rspFlags0, rspFlags1;
    logic [3:0]  aluOp;
    logic [31:0] aluA, aluB, aluResult;
    logic        aluZero, aluNeg, aluOvf;
    logic [31:0] statGrant0, statGrant1, statConflict;

    int checks = 0;
    int errors = 0;

    // Expectations for the cycle currently presented to the DUT
    logic        expGrant0 = 1'b0, expGrant1 = 1'b0;
    logic [3:0]  expOp = 4'd0;
    logic [31:0] expA = 32'd0, expB = 32'd0;
    logic        curValid0 = 1'b0, curValid1 = 1'b0;
    logic [34:0] q0[$];
    logic [34:0] q1[$];

    // Reference state: response slot occupancy, starvation run length, statistics
    logic        mValid0 = 1'b0, mValid1 = 1'b0;
    int          mStarve = 0;
    logic [31:0] mGrant0 = 32'd0, mGrant1 = 32'd0, mConflict = 32'd0;

    always #5 clk = ~clk;

    rv32e_alu_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(reqValid0), .req_ready_0(reqReady0), .req_op_0(reqOp0),
        .req_a_0(reqA0), .req_b_0(reqB0),
        .rsp_valid_0(rspValid0), .rsp_ready_0(rspReady0),
        .rsp_result_0(rspResult0), .rsp_flags_0(rspFlags0),
        .req_valid_1(reqValid1), .req_ready_1(reqReady1), .req_op_1(reqOp1),
        .req_a_1(reqA1), .req_b_1(reqB1),
        .rsp_valid_1(rspValid1), .rsp_ready_1(rspReady1),
        .rsp_result_1(rspResult1), .rsp_flags_1(rspFlags1),
        .alu_op(aluOp), .alu_a(aluA), .alu_b(aluB),
        .alu_result(aluResult), .alu_zero(aluZero), .alu_neg(aluNeg), .alu_ovf(aluOvf),
        .stat_grant0(statGrant0), .stat_grant1(statGrant1), .stat_conflict(statConflict)
    );

    // Behavioural ALU returning {ovf, neg, zero, result}
    function automatic logic [34:0] aluRef(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        ovf;
        ovf = 1'b0;
        case (op)
            4'd0:  begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1:  begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << b[4:0];
            4'd6:  r = a >> b[4:0];
            4'd7:  r = $unsigned($signed(a) >>> b[4:0]);
            4'd8:  r = {31'd0, $signed(a) < $signed(b)};
            4'd9:  r = {31'd0, a < b};
            4'd10: r = {31'd0, a == b};
            4'd11: r = {31'd0, a != b};
            4'd12: r = {31'd0, $signed(a) >= $signed(b)};
            4'd13: r = {31'd0, a >= b};
            4'd14: r = {31'd0, $signed(a) > $signed(b)};
            default: r = {31'd0, a > b};
        endcase
        return {ovf, r[31], (r == 32'd0), r};
    endfunction

    always_comb {aluOvf, aluNeg, aluZero, aluResult} = aluRef(aluOp, aluA, aluB);

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 4))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one cycle of inputs and advance the reference model across the coming edge
    task automatic applyStimulus(input logic rIn,
                                 input logic v0, input logic [3:0] op0, input logic [31:0] a0,
                                 input logic [31:0] b0, input logic rr0,
                                 input logic v1, input logic [3:0] op1, input logic [31:0] a1,
                                 input logic [31:0] b1, input logic rr1);
        logic e0, e1, g0, g1;
        @(posedge clk);
        #1;
        rst = rIn;
        reqValid0 = v0; reqOp0 = op0; reqA0 = a0; reqB0 = b0; rspReady0 = rr0;
        reqValid1 = v1; reqOp1 = op1; reqA1 = a1; reqB1 = b1; rspReady1 = rr1;
        curValid0 = mValid0;
        curValid1 = mValid1;
        if (rIn) begin
            expGrant0 = 1'b0; expGrant1 = 1'b0;
            expOp = 4'd0; expA = 32'd0; expB = 32'd0;
            q0.delete();
            q1.delete();
            mValid0 = 1'b0; mValid1 = 1'b0; mStarve = 0;
            mGrant0 = 32'd0; mGrant1 = 32'd0; mConflict = 32'd0;
        end else begin
            e0 = v0 && (!mValid0 || rr0);
            e1 = v1 && (!mValid1 || rr1);
            g1 = e1 && (!e0 || (mStarve == STARVE_LIMIT));
            g0 = e0 && !g1;
            expGrant0 = g0;
            expGrant1 = g1;
            expOp = 4'd0; expA = 32'd0; expB = 32'd0;
            if (g0) begin
                expOp = op0; expA = a0; expB = b0;
                q0.push_back(aluRef(op0, a0, b0));
                mGrant0 = mGrant0 + 32'd1;
            end else if (g1) begin
                expOp = op1; expA = a1; expB = b1;
                q1.push_back(aluRef(op1, a1, b1));
                mGrant1 = mGrant1 + 32'd1;
            end
            if (e0 && e1) mConflict = mConflict + 32'd1;
            mValid0 = g0 || (mValid0 && !rr0);
            mValid1 = g1 || (mValid1 && !rr1);
            mStarve = (!e1 || g1) ? 0 : mStarve + 1;
        end
    endtask

    task automatic idleCycle(input logic rr0, input logic rr1);
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, rr0, 1'b0, 4'd0, 32'd0, 32'd0, rr1);
    endtask

    task automatic checkStats(input logic [31:0] g0, input logic [31:0] g1, input logic [31:0] c);
`ifdef ALU_ARB_STATS_EN
        checkValue("statGrant0", statGrant0, g0);
        checkValue("statGrant1", statGrant1, g1);
        checkValue("statConflict", statConflict, c);
`else
        checkValue("statGrant0Off", statGrant0, 32'd0 & g0);
        checkValue("statGrant1Off", statGrant1, 32'd0 & g1);
        checkValue("statConflictOff", statConflict, 32'd0 & c);
`endif
    endtask

    // Monitor: handshake and drive checks, plus scoreboard pops on consumed responses
    task automatic checkOutput();
        logic [34:0] front;
        checkValue("reqReady0", 32'(reqReady0), 32'(expGrant0));
        checkValue("reqReady1", 32'(reqReady1), 32'(expGrant1));
        checkValue("aluOp", 32'(aluOp), 32'(expOp));
        checkValue("aluA", aluA, expA);
        checkValue("aluB", aluB, expB);
        checkValue("rspValid0", 32'(rspValid0), 32'(curValid0));
        checkValue("rspValid1", 32'(rspValid1), 32'(curValid1));
        if (!rst && rspValid0) begin
            if (q0.size() == 0) begin
                checkValue("rsp0QueueEmpty", 32'd1, 32'd0);
            end else begin
                front = q0[0];
                checkValue("rspResult0", rspResult0, front[31:0]);
                checkValue("rspFlags0", 32'(rspFlags0), 32'(front[34:32]));
                if (rspReady0) void'(q0.pop_front());
            end
        end
        if (!rst && rspValid1) begin
            if (q1.size() == 0) begin
                checkValue("rsp1QueueEmpty", 32'd1, 32'd0);
            end else begin
                front = q1[0];
                checkValue("rspResult1", rspResult1, front[31:0]);
                checkValue("rspFlags1", 32'(rspFlags1), 32'(front[34:32]));
                if (rspReady1) void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) checkOutput();

    initial begin
        logic [9:0] pattern;
        pattern = 10'b10_0001_0000;

        $display("[TB] reset and idle drive");
        repeat (2) idleCycle(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        repeat (3) idleCycle(1'b1, 1'b1);
        checkValue("resetResult0", rspResult0, 32'd0);
        checkValue("resetFlags1", 32'(rspFlags1), 32'd0);
        checkStats(32'd0, 32'd0, 32'd0);

        $display("[TB] single port ADD overflow");
        applyStimulus(1'b0, 1'b1, 4'd0, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        idleCycle(1'b1, 1'b1);
        #1;
        checkValue("addValid0", 32'(rspValid0), 32'd1);
        checkValue("addResult0", rspResult0, 32'h8000_0000);
        checkValue("addFlags0", 32'(rspFlags0), 32'b110);
        checkValue("addValid1", 32'(rspValid1), 32'd0);

        $display("[TB] backpressure on port 0");
        applyStimulus(1'b0, 1'b1, 4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 4'd0, 32'd1, 32'd2, 1'b0, 1'b1, 4'd1, $urandom, $urandom, 1'b1);
            #1;
            checkValue("bpReady0", 32'(reqReady0), 32'd0);
            checkValue("bpReady1", 32'(reqReady1), 32'd1);
            checkValue("bpHeld0", rspResult0, 32'd1);
        end
        applyStimulus(1'b0, 1'b1, 4'd4, 32'hF0F0_1234, 32'h0FF0_0000, 1'b1, 1'b1, 4'd1, 32'd9, 32'd3, 1'b1);
        idleCycle(1'b1, 1'b1);
        #1;
        checkValue("regrantValid0", 32'(rspValid0), 32'd1);
        checkValue("regrantResult0", rspResult0, 32'hFF00_1234);

        $display("[TB] reset with both responses held");
        applyStimulus(1'b0, 1'b1, 4'd0, 32'd3, 32'd4, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1, 4'd3, 32'd5, 32'd6, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd0, 32'd7, 32'd8, 1'b1, 1'b1, 4'd0, 32'd9, 32'd1, 1'b1);

        $display("[TB] contention with starvation guard");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b1, 4'd0, 32'(k), 32'(k + 1), 1'b1, 1'b1, 4'd1, 32'd5, 32'd5, 1'b1);
            #1;
            if (k == 0) begin
                checkValue("postResetValid0", 32'(rspValid0), 32'd0);
                checkValue("postResetValid1", 32'(rspValid1), 32'd0);
                checkStats(32'd0, 32'd0, 32'd0);
            end
            checkValue($sformatf("grantPattern%0d", k), 32'(reqReady1), 32'(pattern[k]));
        end
        idleCycle(1'b1, 1'b1);
        #1;
        checkStats(32'd8, 32'd2, 32'd10);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 4000; n++) begin
            applyStimulus(($urandom_range(0, 299) == 0),
                          ($urandom_range(0, 3) != 0), 4'($urandom), randOperand(), randOperand(),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) != 0), 4'($urandom), randOperand(), randOperand(),
                          ($urandom_range(0, 3) != 0));
        end
        idleCycle(1'b1, 1'b1);
        idleCycle(1'b1, 1'b1);
        #1;
        checkStats(mGrant0, mGrant1, mConflict);

        #10;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
